// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_capture
//  Description : Decodes an asynchronous PWM waveform into a duty value
//                (high-time cycles minus 1) and a period (rising edge to
//                rising edge, in clk cycles). Flags a stuck input when no
//                rising edge arrives before the period counter saturates.
//  Ports       : clk         - single clock, rising edge
//                reset       - synchronous, active-high
//                pwm_in      - asynchronous PWM input
//                dato        - recovered duty value (CNT_W bits)
//                periodo     - measured period (CNT_W+1 bits)
//                valid       - one-cycle strobe for a new dato/periodo pair
//                stuck       - no rising edge within the timeout
//                stuck_level - synchronized pwm_in level while stuck
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_capture #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] dato,
  output logic [CNT_W:0]   periodo,
  output logic             valid,
  output logic             stuck,
  output logic             stuck_level
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    STUCK = 2'd3
  } state_t;

  localparam logic [CNT_W:0]   C_CNT_MAX  = '1;
  localparam logic [CNT_W:0]   C_CNT_ONE  = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] C_DATO_MAX = '1;

  // Registered state
  state_t           r_state;
  logic             r_s1, r_s2, r_s2_d;
  // r_v1/r_v2 mark when r_s2 holds a genuine sample of pwm_in rather than
  // the cleared reset value, so the refill of the synchronizer after reset
  // is never mistaken for an observed low level.
  logic             r_v1, r_v2;
  logic             r_seen_low;
  logic [CNT_W:0]   r_hi_cnt;
  logic [CNT_W:0]   r_per_cnt;
  logic [CNT_W-1:0] r_dato;
  logic [CNT_W:0]   r_periodo;
  logic             r_valid;
  logic             r_stuck;
  logic             r_stuck_level;

  // Next-state values
  state_t           w_state_nxt;
  logic             w_seen_low_nxt;
  logic [CNT_W:0]   w_hi_nxt;
  logic [CNT_W:0]   w_per_nxt;
  logic [CNT_W-1:0] w_dato_nxt;
  logic [CNT_W:0]   w_periodo_nxt;
  logic             w_valid_nxt;
  logic             w_stuck_nxt;
  logic             w_stuck_level_nxt;

  // Edge detection and derived values
  logic             w_rise, w_fall;
  logic             w_per_sat;
  logic [CNT_W:0]   w_hi_inc;
  logic [CNT_W:0]   w_hi_m1;
  logic [CNT_W-1:0] w_dato_clamped;
  logic [CNT_W-1:0] w_dato_level;

  assign w_rise    = r_s2 & ~r_s2_d;
  assign w_fall    = ~r_s2 & r_s2_d;
  assign w_per_sat = (r_per_cnt == C_CNT_MAX);
  assign w_hi_inc  = (r_hi_cnt == C_CNT_MAX) ? C_CNT_MAX : r_hi_cnt + C_CNT_ONE;
  assign w_hi_m1   = r_hi_cnt - C_CNT_ONE;
  // High time minus one can exceed the duty width by one bit; clamp it.
  assign w_dato_clamped = (w_hi_m1 > {1'b0, C_DATO_MAX}) ? C_DATO_MAX
                                                         : w_hi_m1[CNT_W-1:0];
  // Duty value reported while stuck: full scale when high, zero when low.
  assign w_dato_level   = r_s2 ? C_DATO_MAX : '0;

  always_comb begin
    w_state_nxt       = r_state;
    w_seen_low_nxt    = r_seen_low | (r_v2 & ~r_s2);
    w_hi_nxt          = r_hi_cnt;
    w_per_nxt         = w_rise ? C_CNT_ONE
                               : (w_per_sat ? C_CNT_MAX : r_per_cnt + C_CNT_ONE);
    w_dato_nxt        = r_dato;
    w_periodo_nxt     = r_periodo;
    w_valid_nxt       = 1'b0;
    w_stuck_nxt       = r_stuck;
    w_stuck_level_nxt = r_stuck_level;

    case (r_state)
      IDLE: begin
        if (w_rise && r_seen_low) begin
          w_hi_nxt    = C_CNT_ONE;
          w_state_nxt = HIGH;
        end else if (w_per_sat) begin
          w_state_nxt       = STUCK;
          w_stuck_nxt       = 1'b1;
          w_stuck_level_nxt = r_s2;
          w_dato_nxt        = w_dato_level;
        end
      end

      HIGH: begin
        if (w_fall) begin
          w_state_nxt = LOW;
        end else if (w_per_sat) begin
          w_state_nxt       = STUCK;
          w_stuck_nxt       = 1'b1;
          w_stuck_level_nxt = r_s2;
          w_dato_nxt        = w_dato_level;
        end else if (r_s2) begin
          w_hi_nxt = w_hi_inc;
        end
      end

      LOW: begin
        // A rise coinciding with saturation still completes the period.
        if (w_rise) begin
          w_dato_nxt    = w_dato_clamped;
          w_periodo_nxt = r_per_cnt;
          w_valid_nxt   = 1'b1;
          w_hi_nxt      = C_CNT_ONE;
          w_state_nxt   = HIGH;
        end else if (w_per_sat) begin
          w_state_nxt       = STUCK;
          w_stuck_nxt       = 1'b1;
          w_stuck_level_nxt = r_s2;
          w_dato_nxt        = w_dato_level;
        end
      end

      STUCK: begin
        w_stuck_level_nxt = r_s2;
        if (w_rise) begin
          // Restart measurement; dato keeps its last tracked value until
          // the following full period produces a fresh one.
          w_stuck_nxt = 1'b0;
          w_hi_nxt    = C_CNT_ONE;
          w_state_nxt = HIGH;
        end else begin
          w_dato_nxt = w_dato_level;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_s1          <= 1'b0;
      r_s2          <= 1'b0;
      r_s2_d        <= 1'b0;
      r_v1          <= 1'b0;
      r_v2          <= 1'b0;
      r_seen_low    <= 1'b0;
      r_hi_cnt      <= '0;
      r_per_cnt     <= '0;
      r_dato        <= '0;
      r_periodo     <= '0;
      r_valid       <= 1'b0;
      r_stuck       <= 1'b0;
      r_stuck_level <= 1'b0;
    end else begin
      r_s1          <= pwm_in;
      r_s2          <= r_s1;
      r_s2_d        <= r_s2;
      r_v1          <= 1'b1;
      r_v2          <= r_v1;
      r_state       <= w_state_nxt;
      r_seen_low    <= w_seen_low_nxt;
      r_hi_cnt      <= w_hi_nxt;
      r_per_cnt     <= w_per_nxt;
      r_dato        <= w_dato_nxt;
      r_periodo     <= w_periodo_nxt;
      r_valid       <= w_valid_nxt;
      r_stuck       <= w_stuck_nxt;
      r_stuck_level <= w_stuck_level_nxt;
    end
  end

  assign dato        = r_dato;
  assign periodo     = r_periodo;
  assign valid       = r_valid;
  assign stuck       = r_stuck;
  assign stuck_level = r_stuck_level;

endmodule
`default_nettype wire

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter CNT_W, default 12, the duty-value width, matching the 12-bit PWM generator in this codebase.
REQ-002 SHALL have clk input, 1 bit: the single clock; all logic SHALL use its rising edge.
REQ-003 SHALL have reset input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have pwm_in input, 1 bit: asynchronous PWM waveform to be decoded.
REQ-005 SHALL have dato output, CNT_W bits: recovered duty value, defined as high-time cycles minus 1.
REQ-006 SHALL have periodo output, CNT_W+1 bits: measured period in clk cycles, rising edge to rising edge.
REQ-007 SHALL have valid output, 1 bit: one-cycle strobe marking a new dato/periodo pair.
REQ-008 SHALL have stuck output, 1 bit: high while no rising edge has been seen within the timeout.
REQ-009 SHALL have stuck_level output, 1 bit: synchronized pwm_in level while stuck=1.

Function
REQ-010 SHALL pass pwm_in through a 2-flop synchronizer (s1, s2) plus a delay flop (s2_d); rise = s2 & ~s2_d; fall = ~s2 & s2_d.
REQ-011 SHALL implement states IDLE, HIGH, LOW, STUCK.
REQ-012 SHALL keep hi_cnt (CNT_W+1 bits) and per_cnt (CNT_W+1 bits), both saturating at all-ones and never wrapping.
REQ-013 SHALL have per_cnt increment every cycle in every state except on a rise cycle, where it loads 1.
REQ-014 SHALL, in IDLE, accept a rise only after s2 has been observed low for at least 1 cycle since reset; a pulse already high at reset release SHALL NOT start a measurement.
REQ-015 SHALL, in IDLE, on an accepted rise, load hi_cnt=1 and per_cnt=1, go to HIGH, and not assert valid.
REQ-016 SHALL, in HIGH, increment hi_cnt each cycle s2=1; on fall, go to LOW with hi_cnt frozen.
REQ-017 SHALL, in LOW, on rise, register dato=min(hi_cnt-1, 2^CNT_W-1) and periodo=per_cnt, pulse valid for exactly 1 cycle, load hi_cnt=1 and per_cnt=1, and go to HIGH.
REQ-018 SHALL give a latency of 3 clk edges from the first edge sampling pwm_in high to the edge at which valid is registered high.
REQ-019 SHALL, when per_cnt reaches all-ones in IDLE, HIGH or LOW, go to STUCK, set stuck=1 and stuck_level=s2, and set dato to all-ones if s2=1 or to 0 if s2=0; periodo and valid SHALL be unchanged.
REQ-020 SHALL, in STUCK, track stuck_level and dato to s2 each cycle, ignore fall, and never assert valid.
REQ-021 SHALL, in STUCK, on rise, clear stuck, load hi_cnt=1 and per_cnt=1, and go to HIGH; the next valid SHALL come only after a full following period.
REQ-022 SHALL hold dato and periodo between updates.
REQ-023 SHALL give a fall and a rise in consecutive cycles no special treatment; a 1-cycle low SHALL count fully (periodo includes it).
REQ-024 SHALL apply no glitch filter; any synchronized edge counts.

Reset
REQ-025 SHALL, while reset=1, force dato=0, periodo=0, valid=0, stuck=0, stuck_level=0, s1=s2=s2_d=0, counters=0, and state IDLE, with the low-observed flag cleared.
REQ-026 SHALL, on reset mid-measurement, discard the partial measurement and emit no valid for it.

Verification
REQ-027 SHALL be verified with: codebase PWM generator, Dato=1000 -> from the second rise onward, valid every 4096 cycles with dato=1000 and periodo=4096.
REQ-028 SHALL be verified with: generator Dato=0 -> dato=0, periodo=4096; Dato=4094 -> dato=4094, periodo=4096.
REQ-029 SHALL be verified with: generator Dato=4095 (constant high) after prior toggling -> stuck=1, stuck_level=1, dato=4095 within 8192 cycles of the last rise; no valid.
REQ-030 SHALL be verified with: pwm_in high at reset release, fall at cycle 50, rises at 100 and 300, fall at 180 -> no valid at the 100 rise; valid at the 300 rise with dato=79 and periodo=200.
REQ-031 SHALL be verified with: reset asserted for 1 cycle in the middle of HIGH -> all outputs 0; the first valid comes only after two further rises.
REQ-032 SHALL be verified with: STUCK low, then a rise, a 10-cycle high, and a rise 30 cycles after the first -> stuck clears at the first rise; valid with dato=9 and periodo=30.
